// File: rtl/sata_fis_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sata_fis_pkg: FIS type codes, receiver state encoding, type/length table.
// Rev 1.0
// ----------------------------------------------------------------------------
package sata_fis_pkg;

  localparam logic [7:0] FIS_REG_D2H      = 8'h34;
  localparam logic [7:0] FIS_PIO_SETUP    = 8'h5F;
  localparam logic [7:0] FIS_SET_DEV_BITS = 8'hA1;
  localparam logic [7:0] FIS_DMA_ACT      = 8'h39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } rx_state_t;

  // Expected frame length in dwords; 0 marks an unsupported type.
  function automatic logic [7:0] fis_expected_len(input logic [7:0] fis_type);
    case (fis_type)
      FIS_REG_D2H, FIS_PIO_SETUP: return 8'd5;
      FIS_SET_DEV_BITS:           return 8'd2;
      FIS_DMA_ACT:                return 8'd1;
      default:                    return 8'd0;
    endcase
  endfunction

  function automatic logic fis_is_known(input logic [7:0] fis_type);
    case (fis_type)
      FIS_REG_D2H, FIS_PIO_SETUP, FIS_SET_DEV_BITS, FIS_DMA_ACT: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sata_fis_ctrl_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sata_fis_ctrl_receiver: control-FIS receiver with valid/ready output; optional SATA_FIS_RX_LEN_CHECK_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module sata_fis_ctrl_receiver
  import sata_fis_pkg::*;
#(
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = $clog2(MAX_LEN + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       i_dat,
  input  logic              i_val,
  input  logic              i_eop,
  input  logic              i_err,
  output logic              i_rdy,
  output logic [7:0]        o_dat_type,
  output logic [7:0]        o_dat_status,
  output logic [7:0]        o_dat_error,
  output logic              o_dat_intr,
  output logic              o_dat_dir,
  output logic [47:0]       o_dat_address,
  output logic [15:0]       o_dat_scount,
  output logic [7:0]        o_dat_estatus,
  output logic [15:0]       o_dat_tcount,
  output logic [31:0]       o_dat_sactive,
  output logic [LEN_W-1:0]  o_dat_len,
  output logic              o_dat_badcrc,
  output logic              o_dat_badlen,
  output logic              o_dat_unknown,
  output logic              o_val,
  input  logic              o_rdy
);

  localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_LEN + 1);

  rx_state_t                state;
  logic [MAX_LEN-1:0][31:0] dw;
  logic [MAX_LEN-1:0][31:0] nxt_dw;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         nxt_cnt;
  logic                     err_acc;
  logic                     nxt_err;
  logic                     beat;
  logic                     first;
  logic                     dec_badlen;
  logic                     dec_unknown;
  logic                     unused_bits;

  assign i_rdy = (state != ST_HOLD) | o_rdy;
  assign beat  = i_val & i_rdy;
  // Any beat taken outside RECV opens a new frame, including one taken in HOLD.
  assign first = (state != ST_RECV);

  always_comb begin
    nxt_dw  = dw;
    nxt_cnt = cnt;
    nxt_err = err_acc;
    if (first) begin
      nxt_dw    = '0;
      nxt_dw[0] = i_dat;
      nxt_cnt   = LEN_W'(1);
      nxt_err   = i_err;
    end else begin
      for (int k = 1; k < MAX_LEN; k++) begin
        if (cnt == LEN_W'(k)) nxt_dw[k] = i_dat;
      end
      if (cnt != CNT_SAT) nxt_cnt = cnt + 1'b1;
      nxt_err = err_acc | i_err;
    end
  end

  always_comb begin
    dec_unknown = ~fis_is_known(nxt_dw[0][7:0]);
`ifdef SATA_FIS_RX_LEN_CHECK_EN
    dec_badlen  = ~dec_unknown & (8'(nxt_cnt) != fis_expected_len(nxt_dw[0][7:0]));
`else
    dec_badlen  = 1'b0;
`endif
  end

  assign unused_bits = ^nxt_dw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      dw            <= '0;
      cnt           <= '0;
      err_acc       <= 1'b0;
      o_val         <= 1'b0;
      o_dat_type    <= '0;
      o_dat_status  <= '0;
      o_dat_error   <= '0;
      o_dat_intr    <= 1'b0;
      o_dat_dir     <= 1'b0;
      o_dat_address <= '0;
      o_dat_scount  <= '0;
      o_dat_estatus <= '0;
      o_dat_tcount  <= '0;
      o_dat_sactive <= '0;
      o_dat_len     <= '0;
      o_dat_badcrc  <= 1'b0;
      o_dat_badlen  <= 1'b0;
      o_dat_unknown <= 1'b0;
    end else begin
      if (beat) begin
        dw      <= nxt_dw;
        cnt     <= nxt_cnt;
        err_acc <= nxt_err;
      end

      case (state)
        ST_IDLE, ST_RECV: begin
          if (beat) state <= i_eop ? ST_HOLD : ST_RECV;
        end
        ST_HOLD: begin
          if (beat)       state <= i_eop ? ST_HOLD : ST_RECV;
          else if (o_rdy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (beat & i_eop) begin
        o_val         <= 1'b1;
        o_dat_type    <= nxt_dw[0][7:0];
        o_dat_status  <= nxt_dw[0][23:16];
        o_dat_error   <= nxt_dw[0][31:24];
        o_dat_intr    <= nxt_dw[0][14];
        o_dat_dir     <= nxt_dw[0][13];
        o_dat_address <= {nxt_dw[2][23:0], nxt_dw[1][23:0]};
        o_dat_scount  <= nxt_dw[3][15:0];
        o_dat_estatus <= nxt_dw[3][31:24];
        o_dat_tcount  <= nxt_dw[4][15:0];
        o_dat_sactive <= nxt_dw[1];
        o_dat_len     <= nxt_cnt;
        o_dat_badcrc  <= nxt_err;
        o_dat_badlen  <= dec_badlen;
        o_dat_unknown <= dec_unknown;
      end else if (o_rdy) begin
        o_val <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
